dcache_sram_rd_ctrl: RTL and testbench



---
 rtl/dcache_pkg.sv | 24 ++
 rtl/dcache_rd_skid.sv | 43 ++++
 rtl/dcache_sram_rd_ctrl.sv | 112 +++++++++++
 tb/tb_dcache_sram_rd_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types, widths and the byte-merge helper for the data-cache SRAM read path.
package dcache_pkg;

  localparam int DCACHE_ADDR_W = 9;
  localparam int DCACHE_DATA_W = 32;
  localparam int DCACHE_BE_W   = DCACHE_DATA_W / 8;

  typedef logic [DCACHE_ADDR_W-1:0] dcache_addr_t;
  typedef logic [DCACHE_DATA_W-1:0] dcache_data_t;
  typedef logic [DCACHE_BE_W-1:0]   dcache_be_t;

  // Byte i comes from wr_word when be[i] is set, otherwise from rd_word.
  function automatic dcache_data_t dcache_byte_merge(dcache_data_t rd_word,
                                                     dcache_data_t wr_word,
                                                     dcache_be_t   be);
    dcache_data_t merged;
    merged = rd_word;
    for (int i = 0; i < DCACHE_BE_W; i++) begin
      if (be[i]) merged[8*i +: 8] = wr_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dcache_rd_skid.sv
// Two-entry response FIFO holding returned SRAM words while the consumer stalls.
module dcache_rd_skid #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  empty,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  // Storage carries no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/dcache_sram_rd_ctrl.sv
// Data-cache SRAM read-port controller: request handshake, 1-cycle read return, skid-buffered responses.
// Define DCACHE_RD_FWD_EN to compile in read-during-write forwarding from the snooped write port.
module dcache_sram_rd_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DCACHE_ADDR_W,
  parameter int DATA_WIDTH = DCACHE_DATA_W,
  parameter int BE_WIDTH   = DCACHE_BE_W
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  input  logic                  snp_wr_en,
  input  logic [ADDR_WIDTH-1:0] snp_wr_addr,
  input  logic [DATA_WIDTH-1:0] snp_wr_data,
  input  logic [BE_WIDTH-1:0]   snp_wr_be
);

  logic [1:0]            cnt;
  logic                  inflight;
  logic                  accept;
  logic                  rsp_hs;
  logic [DATA_WIDTH-1:0] ret_data;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic [1:0]            fifo_count;

  assign sram_rd_addr = req_addr;

  // cnt covers buffered words plus the read in flight, so a full buffer can never be overrun.
  assign req_ready = (cnt != 2'd2);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = inflight || !fifo_empty;
  assign rsp_hs    = rsp_valid && rsp_ready;

  // Returned word bypasses only when nothing is queued ahead of it and it is taken now.
  assign fifo_push = inflight && !(fifo_empty && rsp_ready);
  assign fifo_pop  = !fifo_empty && rsp_ready;

  always_comb begin
    rsp_data = '0;
    if (!fifo_empty)   rsp_data = fifo_head;
    else if (inflight) rsp_data = ret_data;
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      cnt      <= 2'd0;
      inflight <= 1'b0;
    end else begin
      inflight <= accept;
      case ({accept, rsp_hs})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

`ifdef DCACHE_RD_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_data;
  logic [BE_WIDTH-1:0]   fwd_be;

  // Capture a write landing on the accepted address; the SRAM returns pre-write data for it.
  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      fwd_data <= '0;
      fwd_be   <= '0;
    end else if (accept) begin
      if (snp_wr_en && (snp_wr_addr == req_addr)) begin
        fwd_data <= snp_wr_data;
        fwd_be   <= snp_wr_be;
      end else begin
        fwd_be   <= '0;
      end
    end
  end

  assign ret_data = dcache_byte_merge(sram_rd_data, fwd_data, fwd_be);
`else
  logic unused_snp;

  assign ret_data   = sram_rd_data;
  assign unused_snp = ^{snp_wr_en, snp_wr_addr, snp_wr_data, snp_wr_be};
`endif

  logic unused_fifo_count;
  assign unused_fifo_count = ^fifo_count;

  dcache_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk       (rd_clk),
    .rst       (rd_rst),
    .push      (fifo_push),
    .push_data (ret_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_dcache_sram_rd_ctrl.sv
// Directed + scoreboard bench for dcache_sram_rd_ctrl with a behavioural 1-cycle SRAM.
module tb_dcache_sram_rd_ctrl;

  logic        rd_clk;
  logic        rd_rst;
  logic        req_valid;
  logic        req_ready;
  logic [8:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [8:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;
  logic        snp_wr_en;
  logic [8:0]  snp_wr_addr;
  logic [31:0] snp_wr_data;
  logic [3:0]  snp_wr_be;

  logic [31:0] mem [512];
  logic [31:0] sb [$];
  int          n_cmp;
  int          n_err;
  logic        hold_pend;
  logic [31:0] hold_data;

  dcache_sram_rd_ctrl dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .snp_wr_en    (snp_wr_en),
    .snp_wr_addr  (snp_wr_addr),
    .snp_wr_data  (snp_wr_data),
    .snp_wr_be    (snp_wr_be)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  // SRAM: address sampled each edge, old data returned on read-during-write.
  always @(posedge rd_clk) begin
    sram_rd_data <= mem[sram_rd_addr];
    if (snp_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (snp_wr_be[i]) mem[snp_wr_addr][8*i +: 8] <= snp_wr_data[8*i +: 8];
      end
    end
  end

  function automatic logic [31:0] model_read(logic [8:0] a);
    logic [31:0] v;
    v = mem[a];
`ifdef DCACHE_RD_FWD_EN
    if (snp_wr_en && snp_wr_addr == a) begin
      for (int i = 0; i < 4; i++) begin
        if (snp_wr_be[i]) v[8*i +: 8] = snp_wr_data[8*i +: 8];
      end
    end
`endif
    return v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: check responses and log accepts at the falling edge, return 1 unit after the rising edge.
  task automatic tick();
    logic [31:0] exp;
    @(negedge rd_clk);
    if (hold_pend) begin
      chk("hold_valid", {31'd0, rsp_valid}, 32'd1);
      chk("hold_data", rsp_data, hold_data);
    end
    if (rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("rsp_unexpected", {31'd0, rsp_valid}, 32'd0);
      end else begin
        exp = sb.pop_front();
        chk("rsp_data", rsp_data, exp);
      end
    end
    hold_pend = rsp_valid && !rsp_ready;
    hold_data = rsp_data;
    if (req_valid && req_ready) sb.push_back(model_read(req_addr));
    @(posedge rd_clk);
    #1;
  endtask

  task automatic sram_write(input logic [8:0] a, input logic [31:0] d);
    req_valid   = 1'b0;
    snp_wr_en   = 1'b1;
    snp_wr_addr = a;
    snp_wr_data = d;
    snp_wr_be   = 4'hF;
    tick();
    snp_wr_en   = 1'b0;
  endtask

  initial begin
    n_cmp = 0; n_err = 0; hold_pend = 1'b0; hold_data = '0;
    rd_rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    snp_wr_en = 1'b0; snp_wr_addr = '0; snp_wr_data = '0; snp_wr_be = '0;
    tick(); tick();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    rd_rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) sram_write(9'(i), 32'h1111_1111 * i);
    sram_write(9'h1A3, 32'hDEAD_BEEF);
    sram_write(9'h010, 32'h1122_3344);

    // Single read
    req_valid = 1'b1; req_addr = 9'h1A3;
    tick();
    req_valid = 1'b0;
    chk("single_valid", {31'd0, rsp_valid}, 32'd1);
    chk("single_data", rsp_data, 32'hDEAD_BEEF);
    tick();
    chk("single_cnt", {30'd0, dut.cnt}, 32'd0);
    chk("single_idle", {31'd0, rsp_valid}, 32'd0);

    // Streaming 8 reads
    for (int i = 0; i < 8; i++) begin
      req_valid = 1'b1; req_addr = 9'(i);
      chk("strm_ready", {31'd0, req_ready}, 32'd1);
      tick();
      chk("strm_valid", {31'd0, rsp_valid}, 32'd1);
    end
    req_valid = 1'b0;
    tick();
    chk("strm_idle", {31'd0, rsp_valid}, 32'd0);
    chk("strm_sb", sb.size(), 32'd0);

    // Backpressure
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 9'd0;
    chk("bp_ready0", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 9'd1;
    chk("bp_ready1", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 9'd2;
    chk("bp_full", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bp_full2", {31'd0, req_ready}, 32'd0);
    chk("bp_head", rsp_data, 32'h0000_0000);
    rsp_ready = 1'b1;
    chk("bp_pop_no_ready", {31'd0, req_ready}, 32'd0);
    tick();
    chk("bp_ready_after", {31'd0, req_ready}, 32'd1);
    chk("bp_second", rsp_data, 32'h1111_1111);
    tick();
    req_valid = 1'b0;
    chk("bp_third", rsp_data, 32'h2222_2222);
    tick();
    chk("bp_sb", sb.size(), 32'd0);

    // Read-during-write to the same address
    req_valid = 1'b1; req_addr = 9'h010;
    snp_wr_en = 1'b1; snp_wr_addr = 9'h010; snp_wr_data = 32'hAABB_CCDD; snp_wr_be = 4'b0101;
    tick();
    req_valid = 1'b0; snp_wr_en = 1'b0;
`ifdef DCACHE_RD_FWD_EN
    chk("fwd_data", rsp_data, 32'h11BB_33DD);
`else
    chk("fwd_data", rsp_data, 32'h1122_3344);
`endif
    tick();
    req_valid = 1'b1; req_addr = 9'h010;
    tick();
    req_valid = 1'b0;
    snp_wr_en = 1'b1; snp_wr_addr = 9'h010; snp_wr_data = 32'h0; snp_wr_be = 4'hF;
    chk("late_write", rsp_data, 32'h11BB_33DD);
    tick();
    snp_wr_en = 1'b0;
    req_valid = 1'b1; req_addr = 9'h010;
    tick();
    req_valid = 1'b0;
    chk("after_write", rsp_data, 32'h0);
    tick();

    // Reset mid-flight
    req_valid = 1'b1; req_addr = 9'h1A3;
    tick();
    req_valid = 1'b0;
    rd_rst = 1'b1;
    sb.delete();
    hold_pend = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_data", rsp_data, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    rd_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("midrst_quiet", {31'd0, rsp_valid}, 32'd0);
    end

    // Random traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      req_valid = 1'($urandom_range(0, 1));
      req_addr  = 9'($urandom_range(0, 7));
      rsp_ready = 1'($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (sb.size() != 0 || rsp_valid) tick();
    end
    chk("drain_sb", sb.size(), 32'd0);
    chk("drain_valid", {31'd0, rsp_valid}, 32'd0);
    chk("drain_ready", {31'd0, req_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
